// File: rtl/snn_pkg.sv
// snn_pkg: shared types and helpers for the multi-class spiking classifier.
//   state_e     - controller states
//   snn_sw()    - signed score width for a given HEIGHT/WIDTH
//   snn_decode()- sign-magnitude weight to two's complement (negative zero -> 0)
package snn_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACCUM   = 2'd1,
    COMPARE = 2'd2,
    DONE    = 2'd3
  } state_e;

  // Wide enough for HEIGHT full-scale weights of either sign.
  function automatic int snn_sw(input int height, input int width);
    return $clog2(height * (2**width - 1) + 1) + 1;
  endfunction

  // Bit `width` is the sign; the low `width` bits are the magnitude.
  function automatic int snn_decode(input logic [31:0] w, input int width);
    logic [31:0] mag;
    mag = w & ((32'd1 << width) - 32'd1);
    return w[width] ? -int'(mag) : int'(mag);
  endfunction

endpackage

// File: rtl/snn_classify_ctrl_argmax.sv
// snn_argmax_seq: sequential argmax over one score per cycle.
//   vld_i/first_i/last_i - score strobe; first restarts the search
//   idx_i, score_i       - class index and signed score
//   best_idx_o, best_o   - running winner (ties keep the earlier index)
//   second_o             - runner-up, starts at the most negative value
//   res_vld_o            - one-cycle pulse after the last score is consumed
module snn_argmax_seq #(
  parameter int SW = 8,
  parameter int IW = 2
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          vld_i,
  input  logic          first_i,
  input  logic          last_i,
  input  logic [IW-1:0] idx_i,
  input  logic [SW-1:0] score_i,
  output logic [IW-1:0] best_idx_o,
  output logic [SW-1:0] best_o,
  output logic [SW-1:0] second_o,
  output logic          res_vld_o
);

  localparam logic [SW-1:0] MIN_SCORE = {1'b1, {(SW-1){1'b0}}};

  logic [IW-1:0] idx_q, idx_d;
  logic [SW-1:0] best_q, best_d, sec_q, sec_d;
  logic          vld_q;

  always_comb begin
    idx_d  = idx_q;
    best_d = best_q;
    sec_d  = sec_q;
    if (vld_i) begin
      if (first_i) begin
        idx_d  = idx_i;
        best_d = score_i;
        sec_d  = MIN_SCORE;
      end else if ($signed(score_i) > $signed(best_q)) begin
        idx_d  = idx_i;
        best_d = score_i;
        sec_d  = best_q;
      end else if ($signed(score_i) > $signed(sec_q)) begin
        // Covers a tie with best: winner stays, runner-up equals it.
        sec_d  = score_i;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      idx_q  <= '0;
      best_q <= '0;
      sec_q  <= '0;
      vld_q  <= 1'b0;
    end else begin
      idx_q  <= idx_d;
      best_q <= best_d;
      sec_q  <= sec_d;
      vld_q  <= vld_i & last_i;
    end
  end

  assign best_idx_o = idx_q;
  assign best_o     = best_q;
  assign second_o   = sec_q;
  assign res_vld_o  = vld_q;

endmodule

// File: rtl/snn_classify_ctrl.sv
// snn_classify_ctrl: latches a binary pixel vector, accumulates sign-magnitude
// weights for NUM_CLASSES neurons LANES pixels per cycle, then runs a
// sequential argmax with confidence threshold and winner margin.
//   clk_i, rst_ni        - clock, synchronous active-low reset
//   pixels_i, start_i    - pixel vector (sampled on accepted start), request
//   busy_o, done_o       - run in progress, one-cycle result strobe
//   class_out_o          - winning class (0 when unknown)
//   unknown_o            - threshold or margin test failed
//   balance_out_o        - signed winning score
//   scores_out_o         - all class scores (only with SNN_SCORE_DUMP_EN)
// Optional feature macro: SNN_SCORE_DUMP_EN.
module snn_classify_ctrl
  import snn_pkg::*;
#(
  parameter int WIDTH       = 8,
  parameter int HEIGHT      = 784,
  parameter int NUM_CLASSES = 10,
  parameter int LANES       = 4,
  parameter int THRESHOLD   = 0,
  parameter int MARGIN      = 1,
  parameter logic [WIDTH:0] WEIGHTS [0:NUM_CLASSES-1][0:HEIGHT-1] = '{default: '{default: '0}},
  localparam int SW  = snn_sw(HEIGHT, WIDTH),
  localparam int CIW = $clog2(NUM_CLASSES)
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic [HEIGHT-1:0] pixels_i,
  input  logic              start_i,
  output logic              busy_o,
  output logic              done_o,
  output logic [CIW-1:0]    class_out_o,
  output logic              unknown_o,
  output logic [SW-1:0]     balance_out_o
`ifdef SNN_SCORE_DUMP_EN
  ,output logic [NUM_CLASSES*SW-1:0] scores_out_o
`endif
);

  localparam int N  = HEIGHT / LANES;
  localparam int NW = (N > 1) ? $clog2(N) : 1;
  localparam logic signed [SW:0] THR_X = (SW+1)'(THRESHOLD);
  localparam logic signed [SW:0] MAR_X = (SW+1)'(MARGIN);

  if (HEIGHT % LANES != 0) begin : g_bad_lanes
    $error("HEIGHT must be a multiple of LANES");
  end

  state_e                          state_q, state_d;
  logic [HEIGHT-1:0]               pix_q;
  logic [NUM_CLASSES-1:0][SW-1:0]  acc_q;
  logic [NUM_CLASSES-1:0][SW-1:0]  chunk_sum;
  logic [NW-1:0]                   chunk_q;
  logic [CIW-1:0]                  cls_q;
  logic                            done_q, unk_q;
  logic [CIW-1:0]                  class_q;
  logic [SW-1:0]                   bal_q;
  logic                            clr, acc_en, cmp_vld, cmp_first, cmp_last, cap;
  logic [CIW-1:0]                  best_idx;
  logic [SW-1:0]                   best, second;
  logic                            arg_vld;
  logic signed [SW:0]              best_x, gap;
  logic                            unk_d;

  // Next state and datapath strobes.
  always_comb begin
    state_d = state_q;
    clr     = 1'b0;
    acc_en  = 1'b0;
    cmp_vld = 1'b0;
    cap     = 1'b0;
    unique case (state_q)
      IDLE: if (start_i) begin
        clr     = 1'b1;
        state_d = ACCUM;
      end
      ACCUM: begin
        acc_en = 1'b1;
        if (chunk_q == NW'(N-1)) state_d = COMPARE;
      end
      COMPARE: begin
        cmp_vld = 1'b1;
        if (cls_q == CIW'(NUM_CLASSES-1)) state_d = DONE;
      end
      DONE: begin
        cap     = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign cmp_first = (cls_q == '0);
  assign cmp_last  = (cls_q == CIW'(NUM_CLASSES-1));

  // Per-class sum of decoded weights for the set pixels of the current chunk.
  always_comb begin
    int s;
    int idx;
    s   = 0;
    idx = 0;
    chunk_sum = '0;
    for (int c = 0; c < NUM_CLASSES; c++) begin
      s = 0;
      for (int l = 0; l < LANES; l++) begin
        idx = int'(chunk_q) * LANES + l;
        if (pix_q[idx]) s = s + snn_decode(32'(WEIGHTS[c][idx]), WIDTH);
      end
      chunk_sum[c] = SW'(s);
    end
  end

  snn_argmax_seq #(.SW(SW), .IW(CIW)) u_argmax (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .vld_i      (cmp_vld),
    .first_i    (cmp_first),
    .last_i     (cmp_last),
    .idx_i      (cls_q),
    .score_i    (acc_q[cls_q]),
    .best_idx_o (best_idx),
    .best_o     (best),
    .second_o   (second),
    .res_vld_o  (arg_vld)
  );

  // One extra bit so best minus a most-negative runner-up cannot wrap.
  assign best_x = {best[SW-1], best};
  assign gap    = best_x - {second[SW-1], second};
  assign unk_d  = (best_x < THR_X) || (gap < MAR_X);

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      pix_q   <= '0;
      acc_q   <= '0;
      chunk_q <= '0;
      cls_q   <= '0;
      done_q  <= 1'b0;
      unk_q   <= 1'b0;
      class_q <= '0;
      bal_q   <= '0;
    end else begin
      state_q <= state_d;
      done_q  <= cap;
      if (clr) begin
        pix_q   <= pixels_i;
        acc_q   <= '0;
        chunk_q <= '0;
        cls_q   <= '0;
      end
      if (acc_en) begin
        for (int c = 0; c < NUM_CLASSES; c++) acc_q[c] <= acc_q[c] + chunk_sum[c];
        chunk_q <= chunk_q + NW'(1);
      end
      if (cmp_vld) cls_q <= cls_q + CIW'(1);
      if (cap && arg_vld) begin
        unk_q   <= unk_d;
        class_q <= unk_d ? '0 : best_idx;
        bal_q   <= best;
      end
    end
  end

`ifdef SNN_SCORE_DUMP_EN
  logic [NUM_CLASSES*SW-1:0] scores_q;
  always_ff @(posedge clk_i) begin
    if (!rst_ni)              scores_q <= '0;
    else if (cap && arg_vld)  scores_q <= acc_q;
  end
  assign scores_out_o = scores_q;
`endif

  assign busy_o        = (state_q != IDLE);
  assign done_o        = done_q;
  assign class_out_o   = class_q;
  assign unknown_o     = unk_q;
  assign balance_out_o = bal_q;

endmodule

// File: tb/tb_snn_classify_ctrl.sv
module tb_snn_classify_ctrl;

  localparam int WIDTH = 4;
  localparam int HEIGHT = 8;
  localparam int NC = 3;
  localparam int LANES = 2;
  localparam int SW = 8;
  localparam logic [WIDTH:0] WTS [0:NC-1][0:HEIGHT-1] = '{
    '{default: 5'd3},
    '{default: 5'd18},
    '{5'd0, 5'd1, 5'd2, 5'd3, 5'd4, 5'd5, 5'd6, 5'd7}
  };

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [7:0]    pixels = 8'h00;
  logic          busy, done, unknown;
  logic [1:0]    class_out;
  logic [SW-1:0] balance_out;
`ifdef SNN_SCORE_DUMP_EN
  logic [NC*SW-1:0] scores_out;
`endif

  snn_classify_ctrl #(
    .WIDTH(WIDTH), .HEIGHT(HEIGHT), .NUM_CLASSES(NC), .LANES(LANES),
    .THRESHOLD(0), .MARGIN(2), .WEIGHTS(WTS)
  ) dut (
    .clk_i(clk), .rst_ni(rst_n), .pixels_i(pixels), .start_i(start),
    .busy_o(busy), .done_o(done), .class_out_o(class_out),
    .unknown_o(unknown), .balance_out_o(balance_out)
`ifdef SNN_SCORE_DUMP_EN
    , .scores_out_o(scores_out)
`endif
  );

  always #5 clk = ~clk;

  int errs = 0;
  int checks = 0;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic check_outs(input string nm, input int c, input int b, input int u);
    chk({nm, " class"}, int'(class_out), c);
    chk({nm, " balance"}, int'($signed(balance_out)), b);
    chk({nm, " unknown"}, int'(unknown), u);
  endtask

  // Single start pulse; returns edges from the start edge to done (bounded).
  task automatic run(input logic [7:0] p, output int lat);
    @(negedge clk);
    pixels = p;
    start  = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    chk("busy after start", int'(busy), 1);
    lat = 0;
    while (lat < 40) begin
      @(posedge clk);
      #1 lat++;
      if (done) break;
    end
  endtask

  typedef struct {
    logic [7:0] pix;
    int         cls;
    int         bal;
    int         unk;
  } vec_t;

  vec_t vt [3];

  initial begin
    int lat, ndone, dcyc;
    int dn [$];

    vt[0] = '{pix: 8'hFF, cls: 2, bal: 28, unk: 0};
    vt[1] = '{pix: 8'h0F, cls: 0, bal: 12, unk: 0};
    vt[2] = '{pix: 8'h00, cls: 0, bal: 0,  unk: 1};

    repeat (3) @(posedge clk);
    #1;
    chk("reset busy", int'(busy), 0);
    chk("reset done", int'(done), 0);
    check_outs("reset", 0, 0, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Table-driven runs.
    for (int i = 0; i < 3; i++) begin
      run(vt[i].pix, lat);
      chk($sformatf("vec%0d latency", i), lat, 8);
      chk($sformatf("vec%0d busy at done", i), int'(busy), 0);
      check_outs($sformatf("vec%0d", i), vt[i].cls, vt[i].bal, vt[i].unk);
`ifdef SNN_SCORE_DUMP_EN
      if (i == 0) begin
        chk("dump s0", int'($signed(scores_out[0*SW +: SW])), 24);
        chk("dump s1", int'($signed(scores_out[1*SW +: SW])), -16);
        chk("dump s2", int'($signed(scores_out[2*SW +: SW])), 28);
      end
`endif
      @(posedge clk);
      #1 chk($sformatf("vec%0d done drop", i), int'(done), 0);
      check_outs($sformatf("vec%0d hold", i), vt[i].cls, vt[i].bal, vt[i].unk);
    end

    // Extra start pulses and pixel change mid-run must be ignored.
    ndone = 0;
    dcyc  = -1;
    for (int cyc = 0; cyc < 20; cyc++) begin
      @(negedge clk);
      start = (cyc == 0 || cyc == 2 || cyc == 5);
      if (cyc == 0) pixels = 8'hFF;
      if (cyc == 2) pixels = 8'h00;
      @(posedge clk);
      #1;
      if (done) begin
        ndone++;
        dcyc = cyc;
      end
    end
    chk("ignored start done count", ndone, 1);
    chk("ignored start done edge", dcyc, 8);
    check_outs("ignored start", 2, 28, 0);

    // Mid-run reset abandons the run and clears outputs.
    ndone = 0;
    for (int cyc = 0; cyc < 20; cyc++) begin
      @(negedge clk);
      start = (cyc == 0);
      if (cyc == 0) pixels = 8'hFF;
      rst_n = (cyc != 3);
      @(posedge clk);
      #1;
      if (done) ndone++;
    end
    chk("reset run done count", ndone, 0);
    chk("reset run busy", int'(busy), 0);
    check_outs("after reset", 0, 0, 0);
    run(8'h0F, lat);
    chk("post reset latency", lat, 8);
    check_outs("post reset", 0, 12, 0);

    // Start held high: back-to-back runs every N+C+2 cycles.
    @(negedge clk);
    pixels = 8'hFF;
    start  = 1'b1;
    for (int cyc = 0; cyc < 30; cyc++) begin
      @(posedge clk);
      #1;
      if (done) dn.push_back(cyc);
    end
    @(negedge clk);
    start = 1'b0;
    chk("b2b done count", dn.size(), 3);
    if (dn.size() >= 2) begin
      chk("b2b first", dn[0], 8);
      chk("b2b period", dn[1] - dn[0], 9);
    end else begin
      chk("b2b second done seen", dn.size(), 2);
    end
    repeat (12) @(posedge clk);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
